// File: rtl/rx_ctrl.sv
// rx_ctrl: receive-side controller for the UART receiver.
// Owns the receiver enable and configuration so that neither changes mid-frame.
// Captures each completed frame and its parity status into a show-ahead FIFO.
// Keeps a sticky overrun flag and a saturating parity-error counter.
module rx_ctrl #(
    parameter int MAX_DATA_WIDTH = 8,
    parameter int CONF_WIDTH     = 5,
    parameter int FIFO_DEPTH     = 4,
    parameter int FIFO_PTR_WIDTH = 2,
    parameter int PERR_CNT_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic                      conf_wr_i,
    input  logic [CONF_WIDTH-1:0]     conf_i,
    input  logic                      clr_err_i,
    output logic                      rx_en_o,
    output logic [CONF_WIDTH-1:0]     rx_conf_o,
    input  logic                      rx_busy_i,
    input  logic                      rx_done_i,
    input  logic                      rx_parity_error_i,
    input  logic [MAX_DATA_WIDTH-1:0] rx_data_i,
    output logic [MAX_DATA_WIDTH-1:0] data_o,
    output logic                      perr_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [FIFO_PTR_WIDTH:0]   level_o,
    output logic                      conf_pending_o,
    output logic                      overrun_o,
    output logic [PERR_CNT_WIDTH-1:0] perr_cnt_o
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam logic [FIFO_PTR_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [FIFO_PTR_WIDTH:0]   CNT_FULL = (FIFO_PTR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [FIFO_PTR_WIDTH-1:0] PTR_ONE  = 1;
    localparam logic [PERR_CNT_WIDTH-1:0] PERR_ONE = 1;
    localparam logic [PERR_CNT_WIDTH-1:0] PERR_MAX = '1;

    state_t                      state_q;
    logic                        rx_en_q;
    logic [CONF_WIDTH-1:0]       conf_q;
    logic [CONF_WIDTH-1:0]       shadow_q;
    logic                        pending_q;
    logic                        done_q;
    logic                        evt_q;
    logic                        evt_perr_q;
    logic [MAX_DATA_WIDTH-1:0]   evt_data_q;
    logic [MAX_DATA_WIDTH-1:0]   mem_data_q [FIFO_DEPTH];
    logic                        mem_perr_q [FIFO_DEPTH];
    logic [FIFO_PTR_WIDTH-1:0]   wr_ptr_q;
    logic [FIFO_PTR_WIDTH-1:0]   rd_ptr_q;
    logic [FIFO_PTR_WIDTH:0]     count_q;
    logic [FIFO_PTR_WIDTH:0]     count_d;
    logic                        overrun_q;
    logic [PERR_CNT_WIDTH-1:0]   perr_cnt_q;

    logic apply;
    logic pop;
    logic full;
    logic wr_en;

    // The shadow may only be applied when no frame is in flight.
    assign apply = pending_q && ((state_q == ST_OFF) || !rx_busy_i);
    assign pop   = (count_q != '0) && ready_i;
    assign full  = (count_q == CNT_FULL);
    // A full FIFO still takes the frame when the head leaves in the same cycle.
    assign wr_en = evt_q && (!full || pop);

    // Enable sequencer: rx_en_o drops only once the receiver is idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_OFF;
            rx_en_q <= 1'b0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (enable_i) begin
                        state_q <= ST_RUN;
                        rx_en_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!enable_i) begin
                        if (rx_busy_i) begin
                            state_q <= ST_STOP;
                        end else begin
                            state_q <= ST_OFF;
                            rx_en_q <= 1'b0;
                        end
                    end
                end
                ST_STOP: begin
                    // A renewed request aborts the stop even if the frame just ended.
                    if (enable_i) begin
                        state_q <= ST_RUN;
                    end else if (!rx_busy_i) begin
                        state_q <= ST_OFF;
                        rx_en_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_OFF;
                    rx_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Shadow config; a write in an apply cycle refills the shadow and keeps it pending.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            conf_q    <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            if (apply) begin
                conf_q    <= shadow_q;
                pending_q <= 1'b0;
            end
            if (conf_wr_i) begin
                shadow_q  <= conf_i;
                pending_q <= 1'b1;
            end
        end
    end

    // Rising edge of rx_done_i marks one frame; payload is staged for one cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_q     <= 1'b0;
            evt_q      <= 1'b0;
            evt_perr_q <= 1'b0;
            evt_data_q <= '0;
        end else begin
            done_q <= rx_done_i;
            evt_q  <= rx_done_i && !done_q;
            if (rx_done_i && !done_q) begin
                evt_perr_q <= rx_parity_error_i;
                evt_data_q <= rx_data_i;
            end
        end
    end

    // Occupancy next-state.
    always_comb begin
        count_d = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!wr_en && pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // FIFO storage and pointers; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_perr_q[i] <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_data_q[wr_ptr_q] <= evt_data_q;
                mem_perr_q[wr_ptr_q] <= evt_perr_q;
                wr_ptr_q             <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_d;
        end
    end

    // Error status; a same-cycle set or increment wins over clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overrun_q  <= 1'b0;
            perr_cnt_q <= '0;
        end else begin
            if (evt_q && full && !pop) begin
                overrun_q <= 1'b1;
            end else if (clr_err_i) begin
                overrun_q <= 1'b0;
            end
            if (evt_q && evt_perr_q) begin
                if (clr_err_i) begin
                    perr_cnt_q <= PERR_ONE;
                end else if (perr_cnt_q != PERR_MAX) begin
                    perr_cnt_q <= perr_cnt_q + PERR_ONE;
                end
            end else if (clr_err_i) begin
                perr_cnt_q <= '0;
            end
        end
    end

    assign rx_en_o        = rx_en_q;
    assign rx_conf_o      = conf_q;
    assign conf_pending_o = pending_q;
    assign data_o         = mem_data_q[rd_ptr_q];
    assign perr_o         = mem_perr_q[rd_ptr_q];
    assign valid_o        = (count_q != '0);
    assign level_o        = count_q;
    assign overrun_o      = overrun_q;
    assign perr_cnt_o     = perr_cnt_q;

endmodule

// File: tb/tb_rx_ctrl.sv
// Randomized scoreboard bench for rx_ctrl with a queue-based reference model.
module tb_rx_ctrl;

    localparam int DEPTH = 4;
    localparam int M_OFF = 0, M_RUN = 1, M_STOP = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable, conf_wr, clr, busy, done, perr, ready;
    logic [4:0] conf;
    logic [7:0] data;
    logic       rx_en_o, perr_o, valid_o, conf_pending_o, overrun_o;
    logic [4:0] rx_conf_o;
    logic [7:0] data_o, perr_cnt_o;
    logic [2:0] level_o;

    rx_ctrl dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .conf_wr_i(conf_wr), .conf_i(conf),
        .clr_err_i(clr), .rx_en_o(rx_en_o), .rx_conf_o(rx_conf_o), .rx_busy_i(busy),
        .rx_done_i(done), .rx_parity_error_i(perr), .rx_data_i(data), .data_o(data_o),
        .perr_o(perr_o), .valid_o(valid_o), .ready_i(ready), .level_o(level_o),
        .conf_pending_o(conf_pending_o), .overrun_o(overrun_o), .perr_cnt_o(perr_cnt_o)
    );

    always #5 clk = ~clk;

    // Reference model state
    int         m_state;
    bit         m_en, m_pend, m_done_prev, m_evt, m_evt_perr, m_ovr;
    logic [4:0] m_conf, m_shadow;
    logic [7:0] m_evt_data;
    int         m_perr_cnt;
    logic [8:0] m_q[$];
    logic [8:0] sb_q[$];
    bit         fin = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    task automatic model_reset();
        m_state = M_OFF; m_en = 0; m_pend = 0; m_done_prev = 0; m_evt = 0;
        m_evt_perr = 0; m_evt_data = 0; m_ovr = 0; m_conf = 0; m_shadow = 0;
        m_perr_cnt = 0; m_q.delete(); sb_q.delete();
    endtask

    // One clock of the specified behaviour, using the inputs sampled at this edge.
    task automatic model_step();
        bit pop, apply;
        pop   = (m_q.size() > 0) && ready;
        apply = m_pend && (m_state == M_OFF || !busy);
        if (clr) begin m_ovr = 0; m_perr_cnt = 0; end
        if (m_evt && m_evt_perr && m_perr_cnt < 255) m_perr_cnt++;
        if (pop) void'(m_q.pop_front());
        if (m_evt) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back({m_evt_perr, m_evt_data});
                sb_q.push_back({m_evt_perr, m_evt_data});
            end else m_ovr = 1;
        end
        m_evt = done && !m_done_prev;
        if (m_evt) begin m_evt_perr = perr; m_evt_data = data; end
        m_done_prev = done;
        if (apply) begin m_conf = m_shadow; m_pend = 0; end
        if (conf_wr) begin m_shadow = conf; m_pend = 1; end
        case (m_state)
            M_OFF:   if (enable) m_state = M_RUN;
            M_RUN:   if (!enable) m_state = busy ? M_STOP : M_OFF;
            default: if (enable) m_state = M_RUN; else if (!busy) m_state = M_OFF;
        endcase
        m_en = (m_state != M_OFF);
    endtask

    task automatic drive_rand(input int rdy_pct, input int perr_pct, input int en_flip,
                              input int clr_pct, input int done_flip);
        if ($urandom_range(99) < 32'(en_flip)) enable = ~enable;
        if ($urandom_range(99) < 20) busy = ~busy;
        if ($urandom_range(99) < 32'(done_flip)) done = ~done;
        perr    = $urandom_range(99) < 32'(perr_pct);
        data    = 8'($urandom);
        ready   = $urandom_range(99) < 32'(rdy_pct);
        conf_wr = $urandom_range(99) < 10;
        conf    = 5'($urandom);
        clr     = $urandom_range(99) < 32'(clr_pct);
    endtask

    task automatic cycle(input int rdy_pct, input int perr_pct, input int en_flip,
                         input int clr_pct, input int done_flip);
        @(posedge clk);
        model_step();
        #1;
        drive_rand(rdy_pct, perr_pct, en_flip, clr_pct, done_flip);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Stimulus
    initial begin
        rst = 1; enable = 0; conf_wr = 0; clr = 0; busy = 0; done = 0; perr = 0;
        ready = 0; conf = 0; data = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        repeat (400) cycle(50, 30, 5, 3, 40);
        repeat (300) cycle(10, 30, 5, 0, 40);
        repeat (700) cycle(100, 100, 5, 0, 100);
        repeat (20) cycle(100, 100, 5, 30, 100);
        // Reset mid-run with frames held in the FIFO
        for (int i = 0; i < 200 && m_q.size() < 2; i++) cycle(0, 30, 5, 0, 50);
        #2 rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        repeat (400) cycle(60, 40, 5, 3, 40);
        enable = 0; done = 0; ready = 1; busy = 0; conf_wr = 0; clr = 0;
        repeat (40) begin
            @(posedge clk);
            model_step();
        end
        #1 fin = 1;
    end

    // Monitor: compare registered outputs with the model and the head with the scoreboard.
    always @(negedge clk) begin
        if (fin) begin
            chk("sb_drained", 32'(sb_q.size()), 32'd0);
            $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
            $finish;
        end else if (rst) begin
            chk("rst_rx_en", 32'(rx_en_o), 0);
            chk("rst_conf", 32'(rx_conf_o), 0);
            chk("rst_data", 32'(data_o), 0);
            chk("rst_perr", 32'(perr_o), 0);
            chk("rst_valid", 32'(valid_o), 0);
            chk("rst_level", 32'(level_o), 0);
            chk("rst_pending", 32'(conf_pending_o), 0);
            chk("rst_overrun", 32'(overrun_o), 0);
            chk("rst_perr_cnt", 32'(perr_cnt_o), 0);
        end else begin
            chk("rx_en", 32'(rx_en_o), 32'(m_en));
            chk("rx_conf", 32'(rx_conf_o), 32'(m_conf));
            chk("pending", 32'(conf_pending_o), 32'(m_pend));
            chk("level", 32'(level_o), 32'(m_q.size()));
            chk("valid", 32'(valid_o), 32'(m_q.size() > 0));
            chk("overrun", 32'(overrun_o), 32'(m_ovr));
            chk("perr_cnt", 32'(perr_cnt_o), 32'(m_perr_cnt));
            if (valid_o) begin
                if (sb_q.size() == 0) begin
                    chk("sb_nonempty", 32'(valid_o), 32'd0);
                end else begin
                    chk("head_data", 32'(data_o), 32'(sb_q[0][7:0]));
                    chk("head_perr", 32'(perr_o), 32'(sb_q[0][8]));
                    if (ready) void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/rx_ctrl.md
# rx_ctrl

Receive-side controller for the UART receiver. Sequences the receiver's enable and configuration so that neither changes mid-frame, and captures each completed frame plus its parity status into a small show-ahead FIFO. Exposes a valid/ready read port, a sticky overrun flag and a saturating parity-error counter to the host/register side.

## Interface
- MAX_DATA_WIDTH, 8, frame data width
- CONF_WIDTH, 5, receiver config width {data[1:0], stop[1:0], parity_en}
- FIFO_DEPTH, 4, entries; power of two, >= 2
- FIFO_PTR_WIDTH, 2, log2(FIFO_DEPTH)
- PERR_CNT_WIDTH, 8, parity error counter width
- clk_i  in  1  system clock; one clock domain
- rst_i  in  1  reset, asynchronous, active-high
- enable_i  in  1  host request: receiver on (level)
- conf_wr_i  in  1  single-cycle pulse; latch conf_i into shadow
- conf_i  in  CONF_WIDTH  new receiver configuration
- clr_err_i  in  1  single-cycle pulse; clear overrun_o and perr_cnt_o
- rx_en_o  out  1  receiver enable
- rx_conf_o  out  CONF_WIDTH  active receiver configuration
- rx_busy_i  in  1  receiver mid-frame
- rx_done_i  in  1  frame complete; may stay high several clk cycles
- rx_parity_error_i  in  1  parity error for the completed frame (level)
- rx_data_i  in  MAX_DATA_WIDTH  received frame data
- data_o  out  MAX_DATA_WIDTH  FIFO head data
- perr_o  out  1  parity error flag of FIFO head entry
- valid_o  out  1  FIFO non-empty
- ready_i  in  1  host pop; pop occurs when valid_o && ready_i
- level_o  out  FIFO_PTR_WIDTH+1  FIFO occupancy
- conf_pending_o  out  1  shadow config not yet applied
- overrun_o  out  1  sticky: frame dropped because FIFO full
- perr_cnt_o  out  PERR_CNT_WIDTH  count of frames with parity error, saturating

## Operation
- FSM states: Off, Run, Stopping. Reset -> Off.
- Off: rx_en_o=0. enable_i=1 -> Run next cycle (rx_en_o=1 from that cycle).
- Run: rx_en_o=1. enable_i=0 and rx_busy_i=0 -> Off; enable_i=0 and rx_busy_i=1 -> Stopping.
- Stopping: rx_en_o=1 held. rx_busy_i=0 -> Off. enable_i=1 -> Run (abort stop). Frames completing in Stopping are captured normally.
- Config: conf_wr_i writes shadow and sets conf_pending_o next cycle. Shadow copied to rx_conf_o, pending cleared, in any cycle with pending=1 and (state==Off or rx_busy_i=0). conf_wr_i in the same cycle as an apply: new value goes to shadow, pending stays 1. rx_conf_o never changes while rx_busy_i=1.
- Frame capture: done_d registers rx_done_i; capture event = rx_done_i && !done_d. On event write {rx_parity_error_i, rx_data_i} to FIFO.
- FIFO: show-ahead; data_o/perr_o valid whenever valid_o=1. Pointers wrap modulo FIFO_DEPTH; level_o in 0..FIFO_DEPTH.
- Full + event + pop in same cycle: write accepted, level unchanged. Full + event, no pop: frame dropped, overrun_o=1 next cycle. Empty + pop: ignored (valid_o=0).
- perr_cnt_o increments on every capture event with rx_parity_error_i=1, including dropped frames; saturates at all-ones.
- clr_err_i clears overrun_o and perr_cnt_o; a same-cycle set/increment wins (overrun_o=1, perr_cnt_o=1).
- FIFO contents preserved across Off; only reset flushes.

## Timing
- Reset values: rx_en_o=0, rx_conf_o=0, data_o=0, perr_o=0, valid_o=0, level_o=0, conf_pending_o=0, overrun_o=0, perr_cnt_o=0; FSM Off; done_d=0; shadow=0.
- Capture latency: rx_done_i rises sampled at edge N -> valid_o/level_o updated after edge N+1 (one-cycle edge-detect register, one-cycle write).
- Pop: at edge with valid_o && ready_i, head advances; next entry on data_o in the following cycle, no bubble.
- Config apply: one cycle after the enabling condition is sampled.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Reset mid-frame with FIFO level 2 -> all outputs return to reset values asynchronously; valid_o=0, rx_en_o=0.
- enable_i=1, three frames 0xA5, 0x3C, 0xFF with rx_done_i held 4 cycles each -> exactly 3 entries, popped in order, perr_o=0, level_o 3->0.
- conf_wr_i conf_i=5'b10011 while rx_busy_i=1 -> rx_conf_o unchanged, conf_pending_o=1; rx_busy_i falls -> rx_conf_o=5'b10011 next cycle, pending=0.
- Fill 4 entries, 5th frame with ready_i=0 -> dropped, overrun_o=1, level_o=4; repeat with ready_i=1 on event cycle -> accepted, overrun_o unchanged.
- 257 frames with rx_parity_error_i=1 (ready_i=1) -> perr_cnt_o=255, each entry perr_o=1; clr_err_i -> 0.
- enable_i falls while rx_busy_i=1 -> Stopping, rx_en_o=1 until busy falls, frame captured, then rx_en_o=0.
